// File: rtl/corr_sync_pkg.sv
// Shared types and width helpers for the correlator peak/symbol-sync path.
package corr_sync_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } sync_state_t;

  // Signed-distance metric needs one bit more than the raw sum.
  function automatic int metric_w(input int sum_w);
    return sum_w + 1;
  endfunction

  function automatic int corr_max(input int n, input int width_in);
    return n * ((1 << width_in) - 1);
  endfunction

endpackage

// File: rtl/corr_metric.sv
// Combinational sum-to-metric conversion: m = |2*sum - MAX|, bit = 2*sum > MAX.
module corr_metric
  import corr_sync_pkg::*;
#(
  parameter int N        = 8,
  parameter int WIDTH_IN = 1,
  parameter int SUM_W    = WIDTH_IN + $clog2(N + 1) - 1,
  parameter int MW       = metric_w(SUM_W)
) (
  input  logic [SUM_W-1:0] i_sum,
  output logic [MW-1:0]    o_m,
  output logic             o_bit
);

  localparam logic [MW-1:0] MAXV = MW'(corr_max(N, WIDTH_IN));

  logic [MW-1:0] w_two;

  assign w_two = {i_sum, 1'b0};
  assign o_bit = (w_two > MAXV);
  assign o_m   = o_bit ? (w_two - MAXV) : (MAXV - w_two);

endmodule

// File: rtl/corr_peak_sync.sv
// Peak search, one-window phase acquisition and +/-1 early/late symbol tracking.
module corr_peak_sync
  import corr_sync_pkg::*;
#(
  parameter int N         = 8,
  parameter int WIDTH_IN  = 1,
  parameter int SUM_W     = WIDTH_IN + $clog2(N + 1) - 1,
  parameter int SPS       = 8,
  parameter int LOSS_SYMS = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_valid,
  input  logic [SUM_W-1:0] corr_sum,
  input  logic [SUM_W:0]   thresh,
  output logic             sym_valid,
  output logic             sym_bit,
  output logic [SUM_W:0]   sym_mag,
  output logic             locked,
  output logic             adj_early,
  output logic             adj_late
);

  localparam int MW = metric_w(SUM_W);
  localparam int CW = $clog2(SPS);
  localparam int LW = $clog2(LOSS_SYMS + 1);

  sync_state_t   r_state;
  logic [CW-1:0] r_cnt, r_widx, r_best_idx;
  logic [LW-1:0] r_miss;
  logic [MW-1:0] r_best, r_mprev, r_mstrb;
  logic          r_arm;

  logic [MW-1:0] w_m;
  logic          w_bit, w_upd, w_strong, w_loss;

  corr_metric #(.N(N), .WIDTH_IN(WIDTH_IN), .SUM_W(SUM_W), .MW(MW)) u_metric (
    .i_sum (corr_sum),
    .o_m   (w_m),
    .o_bit (w_bit)
  );

  assign w_upd    = (w_m > r_best);
  assign w_strong = (w_m >= thresh);
  assign w_loss   = !w_strong && (r_miss == LW'(LOSS_SYMS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= SEARCH;
      r_cnt      <= '0;
      r_widx     <= '0;
      r_best_idx <= '0;
      r_miss     <= '0;
      r_best     <= '0;
      r_mprev    <= '0;
      r_mstrb    <= '0;
      r_arm      <= 1'b0;
      sym_valid  <= 1'b0;
      sym_bit    <= 1'b0;
      sym_mag    <= '0;
      locked     <= 1'b0;
      adj_early  <= 1'b0;
      adj_late   <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      adj_early <= 1'b0;
      adj_late  <= 1'b0;
      if (sample_valid) begin
        r_mprev <= w_m;
        case (r_state)
          SEARCH: begin
            if (w_strong) begin
              r_state    <= ACQUIRE;
              r_best     <= w_m;
              r_best_idx <= '0;
              r_widx     <= CW'(1);
            end
          end
          ACQUIRE: begin
            // Strict compare keeps the earliest index on ties.
            if (w_upd) begin
              r_best     <= w_m;
              r_best_idx <= r_widx;
            end
            if (r_widx == CW'(SPS - 1)) begin
              r_state <= TRACK;
              r_cnt   <= w_upd ? r_widx : r_best_idx;
              r_miss  <= '0;
              locked  <= 1'b1;
            end else begin
              r_widx <= r_widx + CW'(1);
            end
          end
          TRACK: begin
            if (r_cnt == '0) begin
              r_mstrb <= w_m;
              if (w_loss) begin
                r_state <= SEARCH;
                r_miss  <= '0;
                r_arm   <= 1'b0;
                locked  <= 1'b0;
              end else begin
                r_miss    <= w_strong ? '0 : r_miss + LW'(1);
                sym_valid <= 1'b1;
                sym_bit   <= w_bit;
                sym_mag   <= w_m;
                // Valley case lands here too: early wins and late stays disarmed.
                if (r_mprev > w_m) begin
                  r_cnt     <= CW'(SPS - 2);
                  adj_early <= 1'b1;
                  r_arm     <= 1'b0;
                end else begin
                  r_cnt <= CW'(SPS - 1);
                  r_arm <= 1'b1;
                end
              end
            end else begin
              if (r_arm && (w_m > r_mstrb)) adj_late <= 1'b1;
              else                          r_cnt    <= r_cnt - CW'(1);
              r_arm <= 1'b0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_corr_peak_sync.sv
// Self-checking bench for corr_peak_sync against an index-based reference model.
module tb_corr_peak_sync;

  localparam int SW = 4, MW = 5, SPS = 8, LOSS = 3, THR = 6, MAXL = 512;

  logic          clk = 1'b0, rst_n = 1'b0, sample_valid = 1'b0;
  logic [SW-1:0] corr_sum = '0;
  logic [MW-1:0] thresh = MW'(THR);
  logic          sym_valid, sym_bit, locked, adj_early, adj_late;
  logic [MW-1:0] sym_mag;

  corr_peak_sync #(.N(8), .WIDTH_IN(1), .SPS(SPS), .LOSS_SYMS(LOSS)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .corr_sum(corr_sum),
    .thresh(thresh), .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_mag(sym_mag),
    .locked(locked), .adj_early(adj_early), .adj_late(adj_late)
  );

  always #5 clk = ~clk;

  // Per valid-sample vector: [9]=sym_valid [8]=bit [7:3]=mag [2]=early [1]=late [0]=locked
  int         sums [MAXL];
  logic [9:0] expv [MAXL];
  logic [9:0] obsv [MAXL];
  int         total = 0, bad = 0, gap_viol = 0;

  function automatic int mm(input int s);
    int d;
    d = 2 * s - 8;
    return (d < 0) ? -d : d;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0; sample_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Works in absolute sample indices: find peak window, then predict each strobe position.
  task automatic build_model(input int L);
    int i, s, bi, t, miss, lend;
    bit lost;
    for (int j = 0; j < MAXL; j++) expv[j] = '0;
    i = 0;
    while (i < L) begin
      while (i < L && mm(sums[i]) < THR) i++;
      if (i + SPS > L) break;
      s = i; bi = 0;
      for (int k = 1; k < SPS; k++) if (mm(sums[s+k]) > mm(sums[s+bi])) bi = k;
      t = s + SPS + bi; miss = 0; lost = 0;
      while (t < L && !lost) begin
        if (mm(sums[t]) >= THR) miss = 0; else miss++;
        if (miss >= LOSS) lost = 1;
        else begin
          expv[t][9]   = 1'b1;
          expv[t][8]   = (2 * sums[t] > 8);
          expv[t][7:3] = 5'(mm(sums[t]));
          if (mm(sums[t-1]) > mm(sums[t])) begin
            expv[t][2] = 1'b1; t += SPS - 1;
          end else if (t + 1 < L && mm(sums[t+1]) > mm(sums[t])) begin
            expv[t+1][1] = 1'b1; t += SPS + 1;
          end else t += SPS;
        end
      end
      lend = lost ? t : L;
      for (int j = s + SPS - 1; j < lend; j++) expv[j][0] = 1'b1;
      if (!lost) break;
      i = t + 1;
    end
  endtask

  task automatic run(input int L, input int gap_pct);
    logic lk_prev;
    gap_viol = 0;
    lk_prev = locked;
    for (int j = 0; j < L; j++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        sample_valid = 1'b0; corr_sum = SW'($urandom);
        @(posedge clk); #1;
        if (sym_valid || adj_early || adj_late || (locked !== lk_prev)) gap_viol++;
      end
      sample_valid = 1'b1; corr_sum = SW'(sums[j]);
      @(posedge clk); #1;
      obsv[j] = {sym_valid, sym_valid & sym_bit, sym_valid ? sym_mag : 5'd0,
                 adj_early, adj_late, locked};
      lk_prev = locked;
    end
    sample_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    for (int j = 0; j < 14; j++) sums[j] = (j % 8 == 3) ? 8 : 4;
    apply_reset();
    run(14, 0);
    rst_n = 1'b0; #1;
    total++;
    if ({sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late} !== '0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 60; j++) sums[j] = 4;
    build_model(60);
    run(60, 0);
    for (int j = 0; j < 60; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL idle sample %0d: got %b want %b", j, obsv[j], expv[j]);
      end
    end
  endtask

  task automatic test_acquire(input bit neg);
    for (int j = 0; j < 60; j++) sums[j] = (j % 8 == 3) ? (neg ? 0 : 8) : 4;
    apply_reset();
    build_model(60);
    run(60, 0);
    for (int j = 0; j < 60; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL acquire%0d sample %0d: got %b want %b", neg, j, obsv[j], expv[j]);
      end
    end
    total++;
    if (obsv[9][0] !== 1'b0 || obsv[10][0] !== 1'b1) begin
      bad++; $display("FAIL lock_rise: got %b%b want 01", obsv[9][0], obsv[10][0]);
    end
    total++;
    if (obsv[11][9:3] !== {1'b1, ~neg, 5'd8} || obsv[19][9:3] !== {1'b1, ~neg, 5'd8}) begin
      bad++; $display("FAIL first_strobes: got %b %b want %b", obsv[11][9:3], obsv[19][9:3], {1'b1, ~neg, 5'd8});
    end
  endtask

  // Peaks on an 8-grid up to 27, then spacing sp; shoulders (m=6) flank each peak.
  task automatic test_drift(input int sp);
    int p, cnt_adj;
    for (int j = 0; j < 120; j++) sums[j] = 4;
    p = 3;
    while (p < 120) begin
      sums[p] = 8;
      if (p > 0) sums[p-1] = 7;
      if (p + 1 < 120) sums[p+1] = 7;
      p += (p < 27) ? 8 : sp;
    end
    apply_reset();
    build_model(120);
    run(120, 0);
    cnt_adj = 0;
    for (int j = 0; j < 120; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL drift%0d sample %0d: got %b want %b", sp, j, obsv[j], expv[j]);
      end
      if (obsv[j][(sp == 7) ? 2 : 1]) cnt_adj++;
    end
    total++;
    if (cnt_adj < 10) begin
      bad++; $display("FAIL drift%0d_adj_count: got %0d want >=10", sp, cnt_adj);
    end
    total++;
    if (sp == 7 && obsv[35] !== {1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1}) begin
      bad++; $display("FAIL early_first: got %b want 1100110101", obsv[35]);
    end else if (sp == 9 && (obsv[35] !== {1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b1} || obsv[36][1] !== 1'b1)) begin
      bad++; $display("FAIL late_first: got %b late %b want 1100110001 late 1", obsv[35], obsv[36][1]);
    end
  endtask

  task automatic test_loss();
    for (int j = 0; j < 80; j++) sums[j] = (j < 36 && j % 8 == 3) ? 8 : 4;
    apply_reset();
    build_model(80);
    run(80, 0);
    for (int j = 0; j < 80; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL loss sample %0d: got %b want %b", j, obsv[j], expv[j]);
      end
    end
    total++;
    if (obsv[43][9:3] !== 7'b1000000 || obsv[51][9:3] !== 7'b1000000 || obsv[59][9] !== 1'b0) begin
      bad++; $display("FAIL loss_strobes: got %b %b %b want 1000000 1000000 0", obsv[43][9:3], obsv[51][9:3], obsv[59][9]);
    end
    total++;
    if (obsv[58][0] !== 1'b1 || obsv[59][0] !== 1'b0 || obsv[79][0] !== 1'b0) begin
      bad++; $display("FAIL loss_lock: got %b%b%b want 100", obsv[58][0], obsv[59][0], obsv[79][0]);
    end
  endtask

  task automatic test_gaps_reset();
    for (int j = 0; j < 80; j++) sums[j] = (j % 8 == 3) ? 8 : 4;
    apply_reset();
    build_model(80);
    run(80, 30);
    for (int j = 0; j < 80; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL gaps sample %0d: got %b want %b", j, obsv[j], expv[j]);
      end
    end
    total++;
    if (gap_viol != 0) begin
      bad++; $display("FAIL gap_hold: got %0d violations want 0", gap_viol);
    end
    total++;
    if (locked !== 1'b1) begin
      bad++; $display("FAIL pre_reset_lock: got %b want 1", locked);
    end
    #3 rst_n = 1'b0; #1;
    total++;
    if ({sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late} !== '0) begin
      bad++; $display("FAIL midtrack_reset: got %b want 0", {sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) sums[j] = 4;
    build_model(20);
    run(20, 0);
    for (int j = 0; j < 20; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL post_reset sample %0d: got %b want %b", j, obsv[j], expv[j]);
      end
    end
  endtask

  task automatic test_random();
    for (int j = 0; j < 300; j++) sums[j] = int'($urandom_range(8));
    apply_reset();
    build_model(300);
    run(300, 20);
    for (int j = 0; j < 300; j++) begin
      total++;
      if (obsv[j] !== expv[j]) begin
        bad++; $display("FAIL random sample %0d: got %b want %b", j, obsv[j], expv[j]);
      end
    end
    total++;
    if (gap_viol != 0) begin
      bad++; $display("FAIL random_gap_hold: got %0d violations want 0", gap_viol);
    end
  endtask

  initial begin
    #1;
    total++;
    if ({sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late} !== '0) begin
      bad++; $display("FAIL power_on_reset: got %b want 0", {sym_valid, sym_bit, sym_mag, locked, adj_early, adj_late});
    end
    test_reset();
    test_acquire(1'b0);
    test_acquire(1'b1);
    test_drift(7);
    test_drift(9);
    test_loss();
    test_gaps_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
